rc_wf_pipe: RTL and testbench

Registered, per-input-port west-first route computation stage with wormhole route locking. It sits between the input buffers and the VC/switch allocators. For every input channel it computes an output port and a requested VC from each head flit against the router's own coordinates. It then holds that route for the packet's body and tail flits and presents the result through a one-deep valid/ready output register.

---
 rtl/rc_wf_pipe.sv | 150 +++++++++++++++
 tb/tb_rc_wf_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rc_wf_pipe.sv
// rc_wf_pipe: per-channel west-first route computation with wormhole route locking
// and a one-deep valid/ready output register. Define RC_ADAPTIVE_EN for adaptive port choice.
module rc_wf_pipe #(
   parameter  int NUM_IN  = 5,
   parameter  int NUM_VC  = 2,
   parameter  int COORD_W = 8,
   parameter  int FLIT_W  = 64,
   localparam int VCW     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [COORD_W-1:0]      cur_x,
   input  logic [COORD_W-1:0]      cur_y,
   input  logic [5*NUM_VC-1:0]     vc_avail,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   input  logic [NUM_IN*FLIT_W-1:0] in_flit,
   output logic [NUM_IN-1:0]       out_valid,
   input  logic [NUM_IN-1:0]       out_ready,
   output logic [NUM_IN*FLIT_W-1:0] out_flit,
   output logic [NUM_IN*3-1:0]     out_port,
   output logic [NUM_IN*VCW-1:0]   out_vc,
   output logic [NUM_IN-1:0]       err
);

   localparam logic [2:0] P_N = 3'd0, P_E = 3'd1, P_S = 3'd2, P_W = 3'd3, P_L = 3'd4;
   localparam logic [2:0] FT_HEAD = 3'b000, FT_BODY = 3'b001, FT_TAIL = 3'b010, FT_SINGLE = 3'b011;

   // Candidates in selection order; west and local exclude every other candidate.
   localparam logic [2:0] CAND_PORT [5] = '{P_W, P_L, P_N, P_S, P_E};

`ifdef RC_ADAPTIVE_EN
   localparam bit ADAPTIVE = 1'b1;
`else
   localparam bit ADAPTIVE = 1'b0;
`endif

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   function automatic logic [VCW-1:0] lowest_vc(input logic [NUM_VC-1:0] m);
      logic [VCW-1:0] r;
      r = '0;
      for (int b = NUM_VC - 1; b >= 0; b--) begin
         if (m[b]) r = VCW'(b);
      end
      return r;
   endfunction

   logic [NUM_VC-1:0] port_avail [5];
   for (genvar p = 0; p < 5; p++) begin : g_avail
      assign port_avail[p] = vc_avail[p*NUM_VC +: NUM_VC];
   end

   for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
      logic [FLIT_W-1:0]  flit;
      logic [COORD_W-1:0] dst_x, dst_y;
      logic [2:0]         ftype;
      logic               is_head, is_single, is_body, is_tail;
      logic [4:0]         cand_en;
      logic               picked, sel_ok, route_ok, proto_err, hs;
      logic [2:0]         sel_port;
      logic [VCW-1:0]     sel_vc;

      state_t             state_q;
      logic [2:0]         lock_port_q;
      logic [VCW-1:0]     lock_vc_q;
      logic               out_valid_q, err_q;
      logic [FLIT_W-1:0]  out_flit_q;
      logic [2:0]         out_port_q;
      logic [VCW-1:0]     out_vc_q;

      assign flit      = in_flit[i*FLIT_W +: FLIT_W];
      assign dst_y     = flit[FLIT_W-1 -: COORD_W];
      assign dst_x     = flit[FLIT_W-COORD_W-1 -: COORD_W];
      assign ftype     = flit[FLIT_W-2*COORD_W-1 -: 3];
      assign is_head   = (ftype == FT_HEAD);
      assign is_single = (ftype == FT_SINGLE);
      assign is_body   = (ftype == FT_BODY);
      assign is_tail   = (ftype == FT_TAIL);

      // NOTE: every variable written here gets a default first, so no latch is inferred.
      always_comb begin
         cand_en[0] = (dst_x < cur_x);
         cand_en[1] = !cand_en[0] && (dst_x == cur_x) && (dst_y == cur_y);
         cand_en[2] = !cand_en[0] && (dst_y > cur_y);
         cand_en[3] = !cand_en[0] && (dst_y < cur_y);
         cand_en[4] = !cand_en[0] && (dst_x > cur_x);
         picked   = 1'b0;
         sel_ok   = 1'b0;
         sel_port = P_L;
         sel_vc   = '0;
         for (int k = 0; k < 5; k++) begin
            // Deterministic mode commits to the first candidate even if it is busy.
            if (!picked && cand_en[k] && (!ADAPTIVE || (|port_avail[CAND_PORT[k]]))) begin
               picked   = 1'b1;
               sel_port = CAND_PORT[k];
               sel_ok   = |port_avail[CAND_PORT[k]];
               sel_vc   = lowest_vc(port_avail[CAND_PORT[k]]);
            end
         end
      end

      assign route_ok    = !((state_q == S_IDLE) && (is_head || is_single)) || sel_ok;
      assign in_ready[i] = (!out_valid_q || out_ready[i]) && route_ok;
      assign hs          = in_valid[i] && in_ready[i];
      assign proto_err   = (state_q == S_IDLE) ? !(is_head || is_single) : !(is_body || is_tail);

      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q     <= S_IDLE;
            lock_port_q <= '0;
            lock_vc_q   <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            out_flit_q  <= '0;
            out_port_q  <= '0;
            out_vc_q    <= '0;
         end else begin
            err_q <= hs && proto_err;
            if (hs && !proto_err) begin
               out_valid_q <= 1'b1;
               out_flit_q  <= flit;
               if (state_q == S_IDLE) begin
                  out_port_q <= sel_port;
                  out_vc_q   <= sel_vc;
                  if (is_head) begin
                     lock_port_q <= sel_port;
                     lock_vc_q   <= sel_vc;
                     state_q     <= S_LOCKED;
                  end
               end else begin
                  out_port_q <= lock_port_q;
                  out_vc_q   <= lock_vc_q;
                  if (is_tail) state_q <= S_IDLE;
               end
            end else if (out_ready[i]) begin
               out_valid_q <= 1'b0;
            end
         end
      end

      assign out_valid[i]                = out_valid_q;
      assign err[i]                      = err_q;
      assign out_flit[i*FLIT_W +: FLIT_W] = out_flit_q;
      assign out_port[i*3 +: 3]          = out_port_q;
      assign out_vc[i*VCW +: VCW]        = out_vc_q;
   end

endmodule

// File: tb/tb_rc_wf_pipe.sv
// Directed bench for rc_wf_pipe with router at (2,2): routing table plus
// blocking, wormhole, back-pressure, protocol-error and reset sequences.
module tb_rc_wf_pipe;

   localparam int NUM_IN = 5;
   localparam int NUM_VC = 2;
   localparam int VCW    = 1;
   localparam int FW     = 64;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [7:0]             cur_x, cur_y;
   logic [5*NUM_VC-1:0]    vc_avail;
   logic [NUM_IN-1:0]      in_valid, in_ready, out_valid, out_ready, err;
   logic [NUM_IN*FW-1:0]   in_flit, out_flit;
   logic [NUM_IN*3-1:0]    out_port;
   logic [NUM_IN*VCW-1:0]  out_vc;

   int n_checks = 0;
   int n_fail   = 0;

   rc_wf_pipe dut (
      .clk(clk), .rst(rst), .cur_x(cur_x), .cur_y(cur_y), .vc_avail(vc_avail),
      .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
      .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
      .out_port(out_port), .out_vc(out_vc), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mk_flit(input logic [2:0] t, input logic [7:0] dx,
                                           input logic [7:0] dy, input logic [44:0] pl);
      return {dy, dx, t, pl};
   endfunction

   function automatic logic [9:0] mk_avail(input logic [1:0] n, input logic [1:0] e,
                                           input logic [1:0] s, input logic [1:0] w,
                                           input logic [1:0] l);
      return {l, w, s, e, n};
   endfunction

   function automatic logic [63:0] flit_of(input int ch);
      return out_flit[ch*FW +: FW];
   endfunction

   function automatic logic [2:0] port_of(input int ch);
      return out_port[ch*3 +: 3];
   endfunction

   function automatic logic vc_of(input int ch);
      return out_vc[ch*VCW +: VCW];
   endfunction

   // Called at posedge+1; presents a flit, checks it is accepted, clocks it in.
   task automatic send(input int ch, input logic [63:0] f, input string tag);
      in_flit[ch*FW +: FW] = f;
      in_valid[ch] = 1'b1;
      #1;
      check({tag, " in_ready"}, in_ready[ch], 1'b1);
      @(posedge clk); #1;
      in_valid[ch] = 1'b0;
   endtask

   typedef struct {
      logic [7:0] dx;
      logic [7:0] dy;
      logic [9:0] avail;
      logic [2:0] port;
      logic       vc;
   } vec_t;

   vec_t vecs [13];

   localparam logic [2:0] HEAD = 3'b000, BODY = 3'b001, TAIL = 3'b010, SINGLE = 3'b011, BAD = 3'b111;

   logic [63:0] f1, f2;

   initial begin
      vecs[0]  = '{8'd1,   8'd3,   mk_avail(3,3,3,3,3), 3'd3, 1'b0};
      vecs[1]  = '{8'd2,   8'd2,   mk_avail(3,3,3,3,3), 3'd4, 1'b0};
      vecs[2]  = '{8'd2,   8'd2,   mk_avail(3,3,3,3,2), 3'd4, 1'b1};
      vecs[3]  = '{8'd3,   8'd3,   mk_avail(3,3,3,3,3), 3'd0, 1'b0};
      vecs[4]  = '{8'd3,   8'd1,   mk_avail(3,3,3,3,3), 3'd2, 1'b0};
      vecs[5]  = '{8'd3,   8'd2,   mk_avail(3,2,3,3,3), 3'd1, 1'b1};
      vecs[6]  = '{8'd2,   8'd0,   mk_avail(3,3,1,3,3), 3'd2, 1'b0};
      vecs[7]  = '{8'd0,   8'd0,   mk_avail(3,3,3,2,3), 3'd3, 1'b1};
      vecs[8]  = '{8'd2,   8'd5,   mk_avail(2,3,3,3,3), 3'd0, 1'b1};
      vecs[9]  = '{8'd255, 8'd2,   mk_avail(3,3,3,3,3), 3'd1, 1'b0};
      vecs[10] = '{8'd1,   8'd2,   mk_avail(0,0,0,3,0), 3'd3, 1'b0};
      vecs[11] = '{8'd3,   8'd3,   mk_avail(1,3,3,3,3), 3'd0, 1'b0};
      vecs[12] = '{8'd2,   8'd255, mk_avail(3,3,3,3,3), 3'd0, 1'b0};

      rst = 1'b1; cur_x = 8'd2; cur_y = 8'd2; vc_avail = '0;
      in_valid = '0; in_flit = '0; out_ready = '1;
      #1;
      check("reset out_valid", out_valid, '0);
      check("reset err", err, '0);
      check("reset out_flit", out_flit[63:0], '0);
      check("reset out_port", out_port, '0);
      check("reset out_vc", out_vc, '0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // Routing table: single flits on ch0 stay in IDLE, so each row is independent.
      for (int v = 0; v < 13; v++) begin
         vc_avail = vecs[v].avail;
         f1 = mk_flit(SINGLE, vecs[v].dx, vecs[v].dy, 45'(v + 100));
         send(0, f1, $sformatf("vec%0d", v));
         check($sformatf("vec%0d out_valid", v), out_valid[0], 1'b1);
         check($sformatf("vec%0d out_port", v), port_of(0), vecs[v].port);
         check($sformatf("vec%0d out_vc", v), vc_of(0), vecs[v].vc);
         check($sformatf("vec%0d out_flit", v), flit_of(0), f1);
         check($sformatf("vec%0d err", v), err[0], 1'b0);
      end
      @(posedge clk); #1;
      check("drain out_valid", out_valid[0], 1'b0);

      // Head to (3,3) with N busy and E offering only VC1.
      vc_avail = mk_avail(0, 2, 3, 3, 3);
      f1 = mk_flit(HEAD, 8'd3, 8'd3, 45'h111);
`ifdef RC_ADAPTIVE_EN
      send(0, f1, "adaptive head");
      check("adaptive head port", port_of(0), 3'd1);
      check("adaptive head vc", vc_of(0), 1'b1);
      send(0, mk_flit(TAIL, 8'd0, 8'd0, 45'h112), "adaptive tail");
      check("adaptive tail port", port_of(0), 3'd1);
      check("adaptive tail vc", vc_of(0), 1'b1);
`else
      in_flit[0*FW +: FW] = f1;
      in_valid[0] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("blocked head in_ready c%0d", c), in_ready[0], 1'b0);
         @(posedge clk); #1;
         check($sformatf("blocked head out_valid c%0d", c), out_valid[0], 1'b0);
      end
      vc_avail = mk_avail(1, 2, 3, 3, 3);
      #1;
      check("unblocked head in_ready", in_ready[0], 1'b1);
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      check("det head out_valid", out_valid[0], 1'b1);
      check("det head port", port_of(0), 3'd0);
      check("det head vc", vc_of(0), 1'b0);
      vc_avail = '0;
      send(0, mk_flit(TAIL, 8'd0, 8'd0, 45'h112), "det tail");
      check("det tail port", port_of(0), 3'd0);
      check("det tail vc", vc_of(0), 1'b0);
`endif

      // Wormhole on ch4: body and tail follow the locked route with no free VCs.
      vc_avail = mk_avail(3, 3, 3, 3, 3);
      send(4, mk_flit(HEAD, 8'd2, 8'd2, 45'h400), "ch4 head");
      check("ch4 head port", port_of(4), 3'd4);
      check("ch4 head vc", vc_of(4), 1'b0);
      vc_avail = '0;
      send(4, mk_flit(BODY, 8'd9, 8'd9, 45'h401), "ch4 body1");
      check("ch4 body1 port", port_of(4), 3'd4);
      check("ch4 body1 vc", vc_of(4), 1'b0);
      send(4, mk_flit(BODY, 8'd0, 8'd0, 45'h402), "ch4 body2");
      check("ch4 body2 port", port_of(4), 3'd4);
      f2 = mk_flit(TAIL, 8'd0, 8'd7, 45'h403);
      send(4, f2, "ch4 tail");
      check("ch4 tail port", port_of(4), 3'd4);
      check("ch4 tail vc", vc_of(4), 1'b0);
      check("ch4 tail flit", flit_of(4), f2);
      check("ch4 tail err", err[4], 1'b0);

      // Back in IDLE: a body and an illegal type are each dropped with an err pulse.
      send(4, mk_flit(BODY, 8'd2, 8'd2, 45'h404), "idle body");
      check("idle body err", err[4], 1'b1);
      check("idle body out_valid", out_valid[4], 1'b0);
      send(4, mk_flit(BAD, 8'd2, 8'd2, 45'h405), "bad type");
      check("bad type err", err[4], 1'b1);
      check("bad type out_valid", out_valid[4], 1'b0);
      @(posedge clk); #1;
      check("err pulse ends", err[4], 1'b0);

      // Back-pressure on ch2.
      vc_avail = mk_avail(3, 3, 3, 3, 3);
      out_ready[2] = 1'b0;
      f1 = mk_flit(SINGLE, 8'd2, 8'd0, 45'h201);
      f2 = mk_flit(SINGLE, 8'd0, 8'd0, 45'h202);
      send(2, f1, "bp first");
      check("bp first out_valid", out_valid[2], 1'b1);
      in_flit[2*FW +: FW] = f2;
      in_valid[2] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("bp in_ready c%0d", c), in_ready[2], 1'b0);
         @(posedge clk); #1;
         check($sformatf("bp hold flit c%0d", c), flit_of(2), f1);
         check($sformatf("bp hold port c%0d", c), port_of(2), 3'd2);
         check($sformatf("bp hold valid c%0d", c), out_valid[2], 1'b1);
      end
      out_ready[2] = 1'b1;
      #1;
      check("bp release in_ready", in_ready[2], 1'b1);
      @(posedge clk); #1;
      in_valid[2] = 1'b0;
      check("bp second flit", flit_of(2), f2);
      check("bp second port", port_of(2), 3'd3);
      @(posedge clk); #1;
      check("bp drained", out_valid[2], 1'b0);

      // Reset while ch1 is mid-packet.
      send(1, mk_flit(HEAD, 8'd1, 8'd3, 45'h101), "ch1 head");
      check("ch1 head port", port_of(1), 3'd3);
      send(1, mk_flit(BODY, 8'd0, 8'd0, 45'h102), "ch1 body");
      check("ch1 body out_valid", out_valid[1], 1'b1);
      rst = 1'b1;
      #1;
      check("mid reset out_valid", out_valid, '0);
      check("mid reset out_port", out_port, '0);
      check("mid reset out_flit", out_flit[2*FW-1:FW], '0);
      check("mid reset err", err, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      send(1, mk_flit(BODY, 8'd0, 8'd0, 45'h103), "post reset body");
      check("post reset body err", err[1], 1'b1);
      check("post reset body out_valid", out_valid[1], 1'b0);
      f1 = mk_flit(HEAD, 8'd3, 8'd3, 45'h104);
      send(1, f1, "post reset head");
      check("post reset head valid", out_valid[1], 1'b1);
      check("post reset head port", port_of(1), 3'd0);
      check("post reset head vc", vc_of(1), 1'b0);
      check("post reset head err", err[1], 1'b0);
      send(1, mk_flit(TAIL, 8'd0, 8'd0, 45'h105), "post reset tail");
      check("post reset tail port", port_of(1), 3'd0);

      @(posedge clk); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
